// File: rtl/adder_array_pkg.sv
// Shared constants and command decode for the adder_array counter bank.
// Optional snapshot feature is enabled with ADDER_ARRAY_SNAPSHOT_EN.
package adder_array_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLR,
    CMD_LOAD,
    CMD_INC,
    CMD_DEC
  } cmd_e;

  // clr > load > (inc xor dec) > hold; inc and dec together cancel to hold.
  function automatic cmd_e decode_cmd(input logic clr, input logic load,
                                      input logic inc, input logic dec);
    cmd_e cmd;
    cmd = CMD_HOLD;
    if (clr)
      cmd = CMD_CLR;
    else if (load)
      cmd = CMD_LOAD;
    else if (inc && !dec)
      cmd = CMD_INC;
    else if (dec && !inc)
      cmd = CMD_DEC;
    return cmd;
  endfunction

endpackage

// File: rtl/adder_array_channel.sv
// Single counter channel: value register, command decode and overflow pulse.
module adder_channel
  import adder_array_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             ovf,
  output logic             at_zero,
  output logic             at_max
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam bit             SAT_MODE = (SATURATE == MODE_SAT);

  cmd_e             cmd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] value_next;
  logic             ovf_next;

  // The extra top bit of sum/diff is the carry or borrow out of WIDTH bits.
  always_comb begin
    cmd        = decode_cmd(clr, load, inc, dec);
    sum        = {1'b0, value} + STEP_EXT;
    diff       = {1'b0, value} - STEP_EXT;
    value_next = value;
    ovf_next   = 1'b0;
    unique case (cmd)
      CMD_CLR:  value_next = '0;
      CMD_LOAD: value_next = load_val;
      CMD_INC: begin
        ovf_next   = sum[WIDTH];
        value_next = (sum[WIDTH] && SAT_MODE) ? '1 : sum[WIDTH-1:0];
      end
      CMD_DEC: begin
        ovf_next   = diff[WIDTH];
        value_next = (diff[WIDTH] && SAT_MODE) ? '0 : diff[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      value <= value_next;
      ovf   <= ovf_next;
    end
  end

  assign at_zero = (value == '0);
  assign at_max  = (value == '1);

endmodule

// File: rtl/adder_array.sv
// Bank of CHANNELS independent up/down counters with overflow pulses.
// Define ADDER_ARRAY_SNAPSHOT_EN to add the snap/snap_out/snap_valid capture.
module adder_array
  import adder_array_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic                      aclk,
  input  logic                      arstn,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       at_zero,
  output logic [CHANNELS-1:0]       at_max
`ifdef ADDER_ARRAY_SNAPSHOT_EN
  ,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] snap_out,
  output logic                      snap_valid
`endif
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("adder_array: WIDTH must be 2..32");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("adder_array: CHANNELS must be 1..16");
  end
  if (STEP < 1 || 64'(STEP) >= (64'(1) << WIDTH)) begin : g_bad_step
    $error("adder_array: STEP must be 1..2^WIDTH-1");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("adder_array: SATURATE must be 0 or 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    adder_channel #(
      .WIDTH   (WIDTH),
      .STEP    (STEP),
      .SATURATE(SATURATE)
    ) u_ch (
      .aclk    (aclk),
      .arstn   (arstn),
      .clr     (clr[i]),
      .load    (load[i]),
      .load_val(load_val[i*WIDTH +: WIDTH]),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .value   (out[i*WIDTH +: WIDTH]),
      .ovf     (ovf[i]),
      .at_zero (at_zero[i]),
      .at_max  (at_max[i])
    );
  end

`ifdef ADDER_ARRAY_SNAPSHOT_EN
  // Samples the register outputs, so the capture is the pre-update value.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      snap_out   <= '0;
      snap_valid <= 1'b0;
    end else if (snap) begin
      snap_out   <= out;
      snap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_array.sv
// Scoreboard bench for adder_array: wrap and saturate instances share stimulus.
module tb_adder_array;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [3:0]  clr = '0, load = '0, inc = '0, dec = '0;
  logic [31:0] load_val = '0;
  logic [31:0] out_w, out_s;
  logic [3:0]  ovf_w, ovf_s, zero_w, zero_s, max_w, max_s;
`ifdef ADDER_ARRAY_SNAPSHOT_EN
  logic        snap = 1'b0;
  logic [31:0] snap_out_w, snap_out_s;
  logic        snap_valid_w, snap_valid_s;
`endif

  typedef struct {
    string       name;
    logic [31:0] ow;
    logic [3:0]  fw;
    logic [31:0] os;
    logic [3:0]  fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  adder_array #(.WIDTH(8), .CHANNELS(4), .STEP(1), .SATURATE(0)) dut_w (
    .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .out(out_w), .ovf(ovf_w), .at_zero(zero_w), .at_max(max_w)
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    , .snap(snap), .snap_out(snap_out_w), .snap_valid(snap_valid_w)
`endif
  );

  adder_array #(.WIDTH(8), .CHANNELS(4), .STEP(1), .SATURATE(1)) dut_s (
    .aclk(aclk), .arstn(arstn), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .out(out_s), .ovf(ovf_s), .at_zero(zero_s), .at_max(max_s)
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    , .snap(snap), .snap_out(snap_out_s), .snap_valid(snap_valid_s)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] zero_mask(input logic [31:0] v);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (v[i*8 +: 8] == 8'h00);
    return m;
  endfunction

  function automatic logic [3:0] max_mask(input logic [31:0] v);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (v[i*8 +: 8] == 8'hFF);
    return m;
  endfunction

  task automatic drive(input string name, input logic [3:0] c, input logic [3:0] l,
                       input logic [3:0] i, input logic [3:0] d, input logic [31:0] lv,
                       input logic [31:0] ow, input logic [3:0] fw,
                       input logic [31:0] os, input logic [3:0] fs);
    @(negedge aclk);
    clr = c; load = l; inc = i; dec = d; load_val = lv;
    q.push_back('{name: name, ow: ow, fw: fw, os: os, fs: fs});
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".out_w"},  out_w,  32'h0);
    chk({name, ".out_s"},  out_s,  32'h0);
    chk({name, ".ovf_w"},  {28'h0, ovf_w},  32'h0);
    chk({name, ".ovf_s"},  {28'h0, ovf_s},  32'h0);
    chk({name, ".zero_w"}, {28'h0, zero_w}, 32'hF);
    chk({name, ".max_w"},  {28'h0, max_w},  32'h0);
  endtask

  // Monitor: outputs settle one edge after the stimulus that queued them.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".out_w"},  out_w, e.ow);
        chk({e.name, ".ovf_w"},  {28'h0, ovf_w},  {28'h0, e.fw});
        chk({e.name, ".out_s"},  out_s, e.os);
        chk({e.name, ".ovf_s"},  {28'h0, ovf_s},  {28'h0, e.fs});
        chk({e.name, ".zero_w"}, {28'h0, zero_w}, {28'h0, zero_mask(e.ow)});
        chk({e.name, ".max_w"},  {28'h0, max_w},  {28'h0, max_mask(e.ow)});
        chk({e.name, ".zero_s"}, {28'h0, zero_s}, {28'h0, zero_mask(e.os)});
        chk({e.name, ".max_s"},  {28'h0, max_s},  {28'h0, max_mask(e.os)});
      end
    end
  end

  initial begin
    #3;
    chk_reset_state("in_reset");
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    chk("in_reset.snap_out", snap_out_w, 32'h0);
    chk("in_reset.snap_valid", {31'h0, snap_valid_w}, 32'h0);
`endif
    #20 arstn = 1'b1;
    #100;
    chk_reset_state("idle_100ns");

    //     name           clr   load  inc   dec   load_val      out_w         fw    out_s         fs
    drive("clr_all",      4'hF, 4'h0, 4'h0, 4'h0, 32'h0,        32'h00000000, 4'h0, 32'h00000000, 4'h0);
    drive("ld254",        4'h0, 4'h1, 4'h0, 4'h0, 32'h000000FE, 32'h000000FE, 4'h0, 32'h000000FE, 4'h0);
    drive("inc_255",      4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h000000FF, 4'h0, 32'h000000FF, 4'h0);
    drive("inc_wrap",     4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h00000000, 4'h1, 32'h000000FF, 4'h1);
    drive("inc_past",     4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h00000001, 4'h0, 32'h000000FF, 4'h1);
    drive("dec_under1",   4'h0, 4'h0, 4'h0, 4'h2, 32'h0,        32'h0000FF01, 4'h2, 32'h000000FF, 4'h2);
    drive("dec_under2",   4'h0, 4'h0, 4'h0, 4'h2, 32'h0,        32'h0000FE01, 4'h0, 32'h000000FF, 4'h2);
    drive("dec_under3",   4'h0, 4'h0, 4'h0, 4'h2, 32'h0,        32'h0000FD01, 4'h0, 32'h000000FF, 4'h2);
    drive("ld_ch1_ff",    4'h0, 4'h2, 4'h0, 4'h0, 32'h0000FF00, 32'h0000FF01, 4'h0, 32'h0000FFFF, 4'h0);
    drive("inc_ch1_top",  4'h0, 4'h0, 4'h2, 4'h0, 32'h0,        32'h00000001, 4'h2, 32'h0000FFFF, 4'h2);
    drive("ld_ch2_5",     4'h0, 4'h4, 4'h0, 4'h0, 32'h00050000, 32'h00050001, 4'h0, 32'h0005FFFF, 4'h0);
    drive("clr_ld_inc",   4'h4, 4'h4, 4'h4, 4'h0, 32'h00070000, 32'h00000001, 4'h0, 32'h0000FFFF, 4'h0);
    drive("ld_inc",       4'h0, 4'h4, 4'h4, 4'h0, 32'h00070000, 32'h00070001, 4'h0, 32'h0007FFFF, 4'h0);
    drive("inc_dec",      4'h0, 4'h0, 4'h4, 4'h4, 32'h0,        32'h00070001, 4'h0, 32'h0007FFFF, 4'h0);
    drive("ld_ch2_ff",    4'h0, 4'h4, 4'h0, 4'h0, 32'h00FF0000, 32'h00FF0001, 4'h0, 32'h00FFFFFF, 4'h0);
    drive("inc_dec_max",  4'h0, 4'h0, 4'h4, 4'h4, 32'h0,        32'h00FF0001, 4'h0, 32'h00FFFFFF, 4'h0);
    drive("all_inc",      4'h0, 4'h0, 4'hF, 4'h0, 32'h0,        32'h01000102, 4'h4, 32'h01FFFFFF, 4'h7);
    drive("all_dec",      4'h0, 4'h0, 4'h0, 4'hF, 32'h0,        32'h00FF0001, 4'h4, 32'h00FEFEFE, 4'h0);
    drive("mixed",        4'h1, 4'h2, 4'h4, 4'h8, 32'h0000AA00, 32'hFF00AA00, 4'hC, 32'h00FFAA00, 4'h8);
    drive("clr_all2",     4'hF, 4'h0, 4'h0, 4'h0, 32'h0,        32'h00000000, 4'h0, 32'h00000000, 4'h0);
    drive("ld_ch3_10",    4'h0, 4'h8, 4'h0, 4'h0, 32'h0A000000, 32'h0A000000, 4'h0, 32'h0A000000, 4'h0);
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    snap = 1'b1;
`endif
    drive("inc_snap",     4'h0, 4'h0, 4'h8, 4'h0, 32'h0,        32'h0B000000, 4'h0, 32'h0B000000, 4'h0);
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    @(posedge aclk);
    #2;
    snap = 1'b0;
    chk("snap.snap_out_w", snap_out_w, 32'h0A000000);
    chk("snap.snap_out_s", snap_out_s, 32'h0A000000);
    chk("snap.snap_valid_w", {31'h0, snap_valid_w}, 32'h1);
    chk("snap.snap_valid_s", {31'h0, snap_valid_s}, 32'h1);
`endif
    drive("clr_all3",     4'hF, 4'h0, 4'h0, 4'h0, 32'h0,        32'h00000000, 4'h0, 32'h00000000, 4'h0);
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    @(posedge aclk);
    #2;
    chk("snap_hold.snap_out_w", snap_out_w, 32'h0A000000);
`endif
    drive("ld_fe",        4'h0, 4'h1, 4'h0, 4'h0, 32'h000000FE, 32'h000000FE, 4'h0, 32'h000000FE, 4'h0);
    drive("inc_ff",       4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h000000FF, 4'h0, 32'h000000FF, 4'h0);
    drive("inc_ovf",      4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h00000000, 4'h1, 32'h000000FF, 4'h1);

    // Assert reset between edges while ovf is high and inc stays requested.
    @(posedge aclk);
    #2;
    arstn = 1'b0;
    #1;
    chk_reset_state("async_rst");
`ifdef ADDER_ARRAY_SNAPSHOT_EN
    chk("async_rst.snap_valid", {31'h0, snap_valid_w}, 32'h0);
`endif
    @(negedge aclk);
    arstn = 1'b1;
    q.push_back('{name: "post_rst", ow: 32'h00000001, fw: 4'h0, os: 32'h00000001, fs: 4'h0});
    drive("post_rst2",    4'h0, 4'h0, 4'h1, 4'h0, 32'h0,        32'h00000002, 4'h0, 32'h00000002, 4'h0);
    drive("idle",         4'h0, 4'h0, 4'h0, 4'h0, 32'h0,        32'h00000002, 4'h0, 32'h00000002, 4'h0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge aclk);
    #3;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
